record_timer_seg_encoder: RTL and testbench



---
 rtl/record_timer_seg_encoder_if.sv | 28 ++
 rtl/record_timer_seg_encoder.sv | 163 ++++++++++++++++
 tb/tb_record_timer_seg_encoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/record_timer_seg_encoder_if.sv
// Control and display bundle between the scan logic / front panel and the
// recording-time encoder. The master drives the control pulses and the scanned
// digit index. The slave (the encoder) drives the segment lines and status.
interface record_timer_seg_encoder_if;
   logic       start;
   logic       stop;
   logic       clear;
   logic [2:0] digit_sel;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       e;
   logic       f;
   logic       g;
   logic       running;
   logic       overflow;

   modport master (
      output start, stop, clear, digit_sel,
      input  a, b, c, d, e, f, g, running, overflow
   );

   modport slave (
      input  start, stop, clear, digit_sel,
      output a, b, c, d, e, f, g, running, overflow
   );
endinterface

// File: rtl/record_timer_seg_encoder.sv
// Elapsed recording time counter (BCD mm:ss) with a registered seven-segment
// pattern for the digit currently scanned by the downstream multiplexer.
// Segments are active-low and ordered a..g from bit 6 down to bit 0.
module record_timer_seg_encoder #(
   parameter int CLK_HZ  = 100000000,
   parameter int MAX_MIN = 59
) (
   input logic                       clock,
   input logic                       reset,
   record_timer_seg_encoder_if.slave tmr
);
   localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [3:0]    MAX_MT    = 4'(MAX_MIN / 10);
   localparam logic [3:0]    MAX_MU    = 4'(MAX_MIN % 10);
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUNNING   = 2'd1,
      PAUSED    = 2'd2,
      SATURATED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          running_q, running_d;
   logic          overflow_q, overflow_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    dig_q [4];   // 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens
   logic [3:0]    dig_d [4];
   logic [3:0]    carry;       // carry[i] = digit i advances this cycle
   logic          tick;
   logic          at_max;
   logic          go;
   logic [3:0]    shown;
   logic [6:0]    seg_q, seg_d;

   function automatic logic [6:0] seg_encode(input logic [3:0] v);
      case (v)
         4'd0:    seg_encode = 7'b0000001;
         4'd1:    seg_encode = 7'b1001111;
         4'd2:    seg_encode = 7'b0010010;
         4'd3:    seg_encode = 7'b0000110;
         4'd4:    seg_encode = 7'b1001100;
         4'd5:    seg_encode = 7'b0100100;
         4'd6:    seg_encode = 7'b0100000;
         4'd7:    seg_encode = 7'b0001111;
         4'd8:    seg_encode = 7'b0000000;
         4'd9:    seg_encode = 7'b0000100;
         default: seg_encode = SEG_BLANK;
      endcase
   endfunction

   // stop outranks start when both arrive together
   assign go     = tmr.start & ~tmr.stop;
   assign tick   = (state_q == RUNNING) && (presc_q == PRESC_MAX);
   assign at_max = (dig_q[3] == MAX_MT) && (dig_q[2] == MAX_MU) &&
                   (dig_q[1] == 4'd5)   && (dig_q[0] == 4'd9);

   // A tick at the ceiling leaves the count alone; the FSM saturates instead
   assign carry[0] = tick & ~at_max;

   // Native BCD ripple: each digit wraps at its own limit and carries upward
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
         if (gi < 3) begin : g_carry
            assign carry[gi+1] = carry[gi] & (dig_q[gi] == LIM);
         end
         assign dig_d[gi] = tmr.clear ? 4'd0 :
                            carry[gi] ? ((dig_q[gi] == LIM) ? 4'd0 : dig_q[gi] + 4'd1) :
                                        dig_q[gi];
      end
   endgenerate

   // Prescaler advances only while running and holds through a pause
   always_comb begin
      presc_d = presc_q;
      if (tmr.clear) begin
         presc_d = '0;
      end else if (tick) begin
         presc_d = '0;
      end else if (state_q == RUNNING) begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Pick the scanned digit; indices 4..7 map to a non-BCD code that blanks
   always_comb begin
      shown = digit_sel_blank() ? 4'hF : dig_q[tmr.digit_sel[1:0]];
      seg_d = seg_encode(shown);
   end

   function automatic logic digit_sel_blank();
      digit_sel_blank = tmr.digit_sel[2];
   endfunction

   // Datapath registers: prescaler, BCD digits and the registered segment pattern
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         seg_q   <= SEG_BLANK;
         for (int i = 0; i < 4; i++) begin
            dig_q[i] <= 4'd0;
         end
      end else begin
         presc_q <= presc_d;
         seg_q   <= seg_d;
         for (int i = 0; i < 4; i++) begin
            dig_q[i] <= dig_d[i];
         end
      end
   end

   // FSM state register, with the status flags registered alongside
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         running_q  <= running_d;
         overflow_q <= overflow_d;
      end
   end

   // FSM next state: clear wins from anywhere, then stop, then start
   always_comb begin
      state_d = state_q;
      if (tmr.clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:      if (go) state_d = RUNNING;
            RUNNING: begin
               if (tmr.stop)          state_d = PAUSED;
               else if (tick && at_max) state_d = SATURATED;
            end
            PAUSED:    if (go) state_d = RUNNING;
            SATURATED: state_d = SATURATED;
            default:   state_d = IDLE;
         endcase
      end
   end

   // FSM outputs, decoded from the next state so they land with it
   always_comb begin
      running_d  = (state_d == RUNNING);
      overflow_d = (state_d == SATURATED);
   end

   assign tmr.a        = seg_q[6];
   assign tmr.b        = seg_q[5];
   assign tmr.c        = seg_q[4];
   assign tmr.d        = seg_q[3];
   assign tmr.e        = seg_q[2];
   assign tmr.f        = seg_q[1];
   assign tmr.g        = seg_q[0];
   assign tmr.running  = running_q;
   assign tmr.overflow = overflow_q;
endmodule

// File: tb/tb_record_timer_seg_encoder.sv
// Self-checking bench for record_timer_seg_encoder. Unit A runs 10 cycles per
// second with a 59-minute ceiling; unit B runs 2 cycles per second with a
// 1-minute ceiling so saturation is reachable quickly.
module tb_record_timer_seg_encoder;
   localparam logic [6:0] SEG0 = 7'b0000001;
   localparam logic [6:0] SEG1 = 7'b1001111;
   localparam logic [6:0] SEG2 = 7'b0010010;
   localparam logic [6:0] SEG3 = 7'b0000110;
   localparam logic [6:0] SEG4 = 7'b1001100;
   localparam logic [6:0] SEG5 = 7'b0100100;
   localparam logic [6:0] SEG6 = 7'b0100000;
   localparam logic [6:0] SEG7 = 7'b0001111;
   localparam logic [6:0] SEG8 = 7'b0000000;
   localparam logic [6:0] SEG9 = 7'b0000100;
   localparam logic [6:0] BLK  = 7'b1111111;

   typedef struct {
      int         secs;
      logic [2:0] sel;
      logic [6:0] exp;
   } vec_t;

   logic clock;
   logic reset;

   record_timer_seg_encoder_if if_a ();
   record_timer_seg_encoder_if if_b ();

   record_timer_seg_encoder #(.CLK_HZ(10), .MAX_MIN(59)) u_a (
      .clock (clock),
      .reset (reset),
      .tmr   (if_a)
   );

   record_timer_seg_encoder #(.CLK_HZ(2), .MAX_MIN(1)) u_b (
      .clock (clock),
      .reset (reset),
      .tmr   (if_b)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n     = 0;     // edges since the last start pulse
   logic [6:0] sbq [$];       // expected segment patterns in flight
   vec_t       rst_tbl [$];
   vec_t       run_tbl [$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000ns");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clock);
      #1;
      n++;
   endtask

   task automatic drive(input bit u, input bit st, input bit sp, input bit cl);
      if (u) begin
         if_b.start = st; if_b.stop = sp; if_b.clear = cl;
      end else begin
         if_a.start = st; if_a.stop = sp; if_a.clear = cl;
      end
   endtask

   task automatic pulse(input bit u, input bit st, input bit sp, input bit cl);
      drive(u, st, sp, cl);
      cyc();
      drive(u, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [6:0] seg_of(input bit u);
      if (u) return {if_b.a, if_b.b, if_b.c, if_b.d, if_b.e, if_b.f, if_b.g};
      return {if_a.a, if_a.b, if_a.c, if_a.d, if_a.e, if_a.f, if_a.g};
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end else begin
         $display("  ok  %-20s %b", name, act);
      end
   endtask

   // Drive a digit index, queue the pattern it must produce, compare after the edge
   task automatic check_seg(input bit u, input logic [2:0] sel, input logic [6:0] exp,
                            input string name);
      logic [6:0] e;
      if (u) if_b.digit_sel = sel;
      else   if_a.digit_sel = sel;
      sbq.push_back(exp);
      cyc();
      e = sbq.pop_front();
      chk($sformatf("%s[sel%0d]", name, sel), seg_of(u), e);
   endtask

   task automatic chk_flags(input bit u, input bit exp_run, input bit exp_ovf, input string name);
      logic r, o;
      r = u ? if_b.running  : if_a.running;
      o = u ? if_b.overflow : if_a.overflow;
      chk({name, ".running"},  {6'b0, r}, {6'b0, exp_run});
      chk({name, ".overflow"}, {6'b0, o}, {6'b0, exp_ovf});
   endtask

   initial begin
      // Reset sweep: every index blank while reset is held
      for (int i = 0; i < 8; i++) rst_tbl.push_back('{0, 3'(i), BLK});
      // Running table: {elapsed seconds, digit index, expected pattern}
      run_tbl.push_back('{1,  3'd0, SEG1});
      run_tbl.push_back('{1,  3'd1, SEG0});
      run_tbl.push_back('{2,  3'd0, SEG2});
      run_tbl.push_back('{3,  3'd0, SEG3});
      run_tbl.push_back('{4,  3'd0, SEG4});
      run_tbl.push_back('{5,  3'd0, SEG5});
      run_tbl.push_back('{6,  3'd0, SEG6});
      run_tbl.push_back('{7,  3'd0, SEG7});
      run_tbl.push_back('{8,  3'd0, SEG8});
      run_tbl.push_back('{9,  3'd0, SEG9});
      run_tbl.push_back('{10, 3'd0, SEG0});
      run_tbl.push_back('{10, 3'd1, SEG1});
      run_tbl.push_back('{59, 3'd0, SEG9});
      run_tbl.push_back('{59, 3'd1, SEG5});
      run_tbl.push_back('{59, 3'd2, SEG0});
      run_tbl.push_back('{59, 3'd3, SEG0});
      run_tbl.push_back('{60, 3'd0, SEG0});
      run_tbl.push_back('{60, 3'd1, SEG0});
      run_tbl.push_back('{60, 3'd2, SEG1});
      run_tbl.push_back('{60, 3'd3, SEG0});
      run_tbl.push_back('{60, 3'd4, BLK});
      run_tbl.push_back('{60, 3'd7, BLK});

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if_a.digit_sel = 3'd0;
      if_b.digit_sel = 3'd0;
      cyc();

      // Reset state
      foreach (rst_tbl[i]) check_seg(1'b0, rst_tbl[i].sel, rst_tbl[i].exp, "rst_blank");
      check_seg(1'b1, 3'd0, BLK, "rst_blank_b");
      chk_flags(1'b0, 1'b0, 1'b0, "rst");
      chk_flags(1'b1, 1'b0, 1'b0, "rst_b");
      reset = 1'b0;
      check_seg(1'b0, 3'd0, SEG0, "idle_zero");
      check_seg(1'b0, 3'd3, SEG0, "idle_zero");

      // First second: exact tick edge and one-cycle segment latency
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      chk_flags(1'b0, 1'b1, 1'b0, "start");
      if_a.digit_sel = 3'd0;
      repeat (9) cyc();
      check_seg(1'b0, 3'd0, SEG0, "pre_tick");
      check_seg(1'b0, 3'd0, SEG1, "post_tick");
      check_seg(1'b0, 3'd1, SEG0, "post_tick");
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk_flags(1'b0, 1'b0, 1'b0, "clear1");
      check_seg(1'b0, 3'd0, SEG0, "clear1_zero");

      // Pause holds both the count and the partial second
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      repeat (5) cyc();
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      chk_flags(1'b0, 1'b0, 1'b0, "paused");
      repeat (50) cyc();
      check_seg(1'b0, 3'd0, SEG0, "pause_hold");
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk_flags(1'b0, 1'b1, 1'b0, "resumed");
      repeat (3) cyc();
      check_seg(1'b0, 3'd0, SEG0, "resume_pre");
      check_seg(1'b0, 3'd0, SEG1, "resume_tick");
      pulse(1'b0, 1'b0, 1'b0, 1'b1);

      // Table run through the minute carry
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      foreach (run_tbl[i]) begin
         while (n < run_tbl[i].secs * 10 + 2) cyc();
         check_seg(1'b0, run_tbl[i].sel, run_tbl[i].exp, $sformatf("tbl_%0ds", run_tbl[i].secs));
      end
      chk_flags(1'b0, 1'b1, 1'b0, "tbl_end");
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk_flags(1'b0, 1'b0, 1'b0, "clear2");

      // Saturation on unit B (01:59 ceiling, 2 cycles per second)
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (n < 236) cyc();
      check_seg(1'b1, 3'd3, SEG0, "b_0158");
      check_seg(1'b1, 3'd2, SEG1, "b_0158");
      check_seg(1'b1, 3'd1, SEG5, "b_0159");
      chk_flags(1'b1, 1'b1, 1'b0, "b_pre_sat");
      check_seg(1'b1, 3'd0, SEG9, "b_0159");
      chk_flags(1'b1, 1'b0, 1'b1, "b_sat");
      check_seg(1'b1, 3'd0, SEG9, "b_sat");
      check_seg(1'b1, 3'd1, SEG5, "b_sat");
      check_seg(1'b1, 3'd2, SEG1, "b_sat");
      check_seg(1'b1, 3'd3, SEG0, "b_sat");
      repeat (10) cyc();
      check_seg(1'b1, 3'd0, SEG9, "b_sat_hold");
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      chk_flags(1'b1, 1'b0, 1'b1, "b_start_ign");
      repeat (4) cyc();
      check_seg(1'b1, 3'd0, SEG9, "b_start_ign");
      pulse(1'b1, 1'b0, 1'b0, 1'b1);
      chk_flags(1'b1, 1'b0, 1'b0, "b_clear");
      check_seg(1'b1, 3'd0, SEG0, "b_clear");
      check_seg(1'b1, 3'd2, SEG0, "b_clear");

      // start+stop+clear together while running
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (n < 25) cyc();
      check_seg(1'b0, 3'd0, SEG2, "combo_pre");
      pulse(1'b0, 1'b1, 1'b1, 1'b1);
      chk_flags(1'b0, 1'b0, 1'b0, "combo");
      check_seg(1'b0, 3'd0, SEG0, "combo");
      check_seg(1'b0, 3'd1, SEG0, "combo");
      repeat (30) cyc();
      check_seg(1'b0, 3'd0, SEG0, "combo_idle");
      chk_flags(1'b0, 1'b0, 1'b0, "combo_idle");

      // Reset coincident with start discards the start
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_flags(1'b0, 1'b0, 1'b0, "rst_start");
      repeat (20) cyc();
      chk_flags(1'b0, 1'b0, 1'b0, "rst_start_idle");
      check_seg(1'b0, 3'd0, SEG0, "rst_start_idle");
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk_flags(1'b0, 1'b1, 1'b0, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
